// File: rtl/alu_operand_stage_if.sv
// Instruction-issue channel into the ALU operand stage: valid/ready handshake
// carrying the opcode, register indices and write enable.
interface alu_operand_stage_if #(
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [AW-1:0] instr_rd;
  logic          instr_we;

  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, instr_we,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd, instr_we,
    output instr_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch / issue stage in front of the ALU: register file, execute
// register driving the ALU, and result write-back with forwarding.
module alu_operand_stage #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  alu_operand_stage_if.slave   instr,
  output logic [DW-1:0]        reg_1,
  output logic [DW-1:0]        reg_2,
  output logic [3:0]           alu_opsel,
  input  logic [DW-1:0]        alu_res,
  output logic                 wb_valid,
  output logic [AW-1:0]        wb_rd,
  output logic [DW-1:0]        wb_data,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DW-1:0]        dbg_data
);

  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] rd;
    logic          we;
  } ex_t;

  logic [DW-1:0] regs [NREGS];
  ex_t           ex;
  logic          accept;
  logic          wb_fire;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  assign instr.instr_ready = !stall;
  assign accept            = instr.instr_valid && !stall;
  assign wb_fire           = ex.valid && ex.we && (ex.rd != '0) && !stall;

  // Operand read with register 0 hard-wired to zero; a result retiring at the
  // same edge bypasses the register file so dependent instructions need no bubble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op_a = '0;
    op_b = '0;
    if (instr.instr_rs1 != '0) op_a = regs[instr.instr_rs1];
    if (instr.instr_rs2 != '0) op_b = regs[instr.instr_rs2];
    if (wb_fire && instr.instr_rs1 == ex.rd) op_a = alu_res;
    if (wb_fire && instr.instr_rs2 == ex.rd) op_b = alu_res;
  end

  // NOTE: the register file clears on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_fire) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      regs[ex.rd] <= alu_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex <= '{valid: 1'b0, op: OP_IDLE, a: '0, b: '0, rd: '0, we: 1'b0};
    end else if (accept) begin
      ex <= '{valid: 1'b1, op: instr.instr_op, a: op_a, b: op_b,
              rd: instr.instr_rd, we: instr.instr_we};
    end else if (!stall) begin
      // An empty slot drives the idle opcode so the ALU output reads as zero.
      ex.valid <= 1'b0;
      ex.op    <= OP_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_rd   <= ex.rd;
        wb_data <= alu_res;
      end
    end
  end

  assign reg_1     = ex.a;
  assign reg_2     = ex.b;
  assign alu_opsel = ex.op;
  assign dbg_data  = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a stub ALU closes the loop and an
// architectural (in-order, one-at-a-time) register model supplies expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] reg_1, reg_2, alu_res, wb_data, dbg_data;
  logic [3:0]  alu_opsel;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] alu_imm = '0;

  alu_operand_stage_if #(.AW(3)) bus ();

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(bus.slave),
    .reg_1(reg_1), .reg_2(reg_2), .alu_opsel(alu_opsel), .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Stand-in ALU. Op 0100 passes an immediate supplied alongside the
  // executing instruction, which is how registers get seeded with constants.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic [31:0] imm);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a & b;
      4'b0010: return a | b;
      4'b0011: return a - b;
      4'b0100: return imm;
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_res = alu_fn(reg_1, reg_2, alu_opsel, alu_imm);

  // Architectural model: arf = registers as seen by program order,
  // crf = registers already written back (what dbg_data should show).
  logic [31:0] arf [8];
  logic [31:0] crf [8];
  logic        p_valid, p_we;
  logic [2:0]  p_rd;
  logic [31:0] p_res, e_a, e_b;
  logic [3:0]  e_op;
  logic        e_wbv;
  logic [2:0]  e_wbrd;
  logic [31:0] e_wbdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      arf[i] = '0;
      crf[i] = '0;
    end
    p_valid = 0; p_we = 0; p_rd = '0; p_res = '0;
    e_a = '0; e_b = '0; e_op = 4'hF;
    e_wbv = 0; e_wbrd = '0; e_wbdata = '0;
  endtask

  task automatic dbg_sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_dbg_r%0d", tag, i), dbg_data, crf[i]);
    end
  endtask

  // One clock cycle: drive at the falling edge, update the model for the
  // rising edge, then compare just after it.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                      input logic we, input logic [31:0] imm, input logic st);
    logic [31:0] a, b, res;
    @(negedge clk);
    bus.instr_valid = v;
    bus.instr_op    = op;
    bus.instr_rs1   = s1;
    bus.instr_rs2   = s2;
    bus.instr_rd    = d;
    bus.instr_we    = we;
    stall           = st;
    @(posedge clk);
    #1;
    if (!st && p_valid && p_we && p_rd != 0) begin
      e_wbv = 1; e_wbrd = p_rd; e_wbdata = p_res; crf[p_rd] = p_res;
    end else begin
      e_wbv = 0;
    end
    if (v && !st) begin
      a   = (s1 == 0) ? 32'h0 : arf[s1];
      b   = (s2 == 0) ? 32'h0 : arf[s2];
      res = alu_fn(a, b, op, imm);
      if (we && d != 0) arf[d] = res;
      p_valid = 1; p_we = we; p_rd = d; p_res = res;
      e_a = a; e_b = b; e_op = op;
      alu_imm = imm;
    end else if (!st) begin
      p_valid = 0;
      e_op = 4'hF;
    end
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'(!st));
    chk({tag, "_opsel"}, 32'(alu_opsel), 32'(e_op));
    if (p_valid) begin
      chk({tag, "_reg_1"}, reg_1, e_a);
      chk({tag, "_reg_2"}, reg_2, e_b);
    end
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(e_wbv));
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(e_wbrd));
    chk({tag, "_wb_data"}, wb_data, e_wbdata);
    dbg_addr = 3'($urandom_range(0, 7));
    #1;
    chk({tag, "_dbg"}, dbg_data, crf[dbg_addr]);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [3:0] rop;
    bus.instr_valid = 0; bus.instr_op = '0; bus.instr_rs1 = '0;
    bus.instr_rs2 = '0; bus.instr_rd = '0; bus.instr_we = 0;
    model_reset();

    // Reset state
    #35;
    dbg_sweep("reset");
    chk("reset_opsel", 32'(alu_opsel), 32'hF);
    chk("reset_wb_valid", 32'(wb_valid), 32'h0);
    chk("reset_ready", 32'(bus.instr_ready), 32'h1);
    @(negedge clk);
    rst = 0;

    // Seed r1=5, r2=7, then r3=r1+r2 and dependent r4=r3-r1 back to back
    step("seed_r1", 1, 4'b0100, 3'd0, 3'd0, 3'd1, 1, 32'd5, 0);
    step("seed_r2", 1, 4'b0100, 3'd0, 3'd0, 3'd2, 1, 32'd7, 0);
    step("add_r3",  1, 4'b0000, 3'd1, 3'd2, 3'd3, 1, 32'h0, 0);
    chk("add_r3_op_a", reg_1, 32'd5);
    chk("add_r3_op_b", reg_2, 32'd7);
    step("sub_r4",  1, 4'b0011, 3'd3, 3'd1, 3'd4, 1, 32'h0, 0);
    chk("sub_r4_fwd", reg_1, 32'd12);
    chk("add_r3_wb", {wb_valid, 28'h0, wb_rd}, {1'b1, 28'h0, 3'd3});
    chk("add_r3_wb_data", wb_data, 32'd12);
    idle("drain1");
    chk("sub_r4_wb_data", wb_data, 32'd7);
    idle("drain2");
    dbg_sweep("after_dep");

    // Stall three cycles with r6=r3+r4 in execute and another instruction waiting
    step("pre_stall", 1, 4'b0000, 3'd3, 3'd4, 3'd6, 1, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 1, 4'b0001, 3'd6, 3'd3, 3'd5, 1, 32'h0, 1);
    step("release", 1, 4'b0001, 3'd6, 3'd3, 3'd5, 1, 32'h0, 0);
    chk("release_wb_data", wb_data, 32'd19);
    idle("after_release");
    idle("after_release2");

    // Write to r0 is dropped; we=0 produces no write
    step("wr_r0", 1, 4'b1011, 3'd1, 3'd0, 3'd0, 1, 32'h0, 0);
    step("we0",   1, 4'b0000, 3'd1, 3'd2, 3'd7, 0, 32'h0, 0);
    chk("wr_r0_no_wb", 32'(wb_valid), 32'h0);
    idle("after_we0");
    chk("we0_no_wb", 32'(wb_valid), 32'h0);
    dbg_sweep("after_r0");

    // Randomized stream with stalls
    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
      step("rand", 1'($urandom_range(0, 4) != 0), rop,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 4) == 0));
    end
    idle("rand_drain1");
    idle("rand_drain2");
    dbg_sweep("after_rand");

    // Asynchronous reset with r5=r1^r2 in execute
    step("pre_rst", 1, 4'b1010, 3'd1, 3'd2, 3'd5, 1, 32'h0, 0);
    rst = 1;
    dbg_addr = 3'd1;
    #1;
    chk("async_rst_opsel", 32'(alu_opsel), 32'hF);
    chk("async_rst_reg_1", reg_1, 32'h0);
    chk("async_rst_reg_2", reg_2, 32'h0);
    chk("async_rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("async_rst_wb_data", wb_data, 32'h0);
    chk("async_rst_dbg_r1", dbg_data, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus.instr_valid = 0;
    idle("post_rst1");
    idle("post_rst2");
    dbg_sweep("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch / issue stage directly upstream of the 32-bit ALU.
- Holds an 8-entry x 32-bit register file and accepts instructions over a valid/ready handshake.
- Registers the opcode and both operands into an execute register that drives the ALU's reg_1, reg_2 and alu_opsel inputs.
- Captures the ALU's combinational alu_res one cycle later and writes it back, with forwarding so that dependent back-to-back instructions run without bubbles.

Parameters:
- NREGS, 8, number of architectural registers; must be a power of 2.
- AW, 3, register index width; equals log2(NREGS).
- DW, 32, datapath width; must match the ALU width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  downstream hold; freezes the execute stage and blocks write-back.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  stage can accept; equals !stall.
- instr_op  input  4  ALU opcode, passed unchanged to alu_opsel.
- instr_rs1  input  AW  source register A.
- instr_rs2  input  AW  source register B.
- instr_rd  input  AW  destination register.
- instr_we  input  1  write result to rd.
- reg_1  output  DW  ALU operand A.
- reg_2  output  DW  ALU operand B.
- alu_opsel  output  4  ALU operation select.
- alu_res  input  DW  combinational ALU result.
- wb_valid  output  1  one-cycle pulse: a register write retired.
- wb_rd  output  AW  register written.
- wb_data  output  DW  value written.
- dbg_addr  input  AW  debug read index.
- dbg_data  output  DW  combinational register-file read at dbg_addr.

Behaviour:
- Reset (asynchronous):
  - All register-file entries clear to 0.
  - ex_valid=0, ex_op=4'b1111, ex_a=0, ex_b=0, ex_rd=0, ex_we=0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - Reset applied mid-operation drops any in-flight instruction; its result is never written.
- Register 0 always reads 0. Writes to register 0 are dropped, with no wb_valid pulse.
- Accept: a transfer occurs at an edge where instr_valid && instr_ready.
- Execute register update:
  - On accept, the execute register loads instr_op, operand A, operand B, rd and we, and ex_valid becomes 1.
  - At an edge with !stall and no accept, ex_valid becomes 0 and ex_op becomes 4'b1111, so the ALU outputs 0.
  - While stall=1, all execute-register fields hold.
- ALU drive: reg_1=ex_a, reg_2=ex_b, alu_opsel=ex_op, all directly from flops with no logic in the path.
- Write-back, at an edge where ex_valid && ex_we && ex_rd!=0 && !stall:
  - regfile[ex_rd] <= alu_res.
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_res.
  - At every other edge, wb_valid <= 0 and wb_rd / wb_data hold.
- Latency:
  - Instruction accepted at edge N appears on the ALU inputs during cycle N..N+1.
  - Its result is written at edge N+1 (absent stall), and wb_valid is high during cycle N+1..N+2.
  - Throughput is one instruction per cycle.
- Forwarding: when accepting at the same edge as a write-back, and instr_rsX == ex_rd (nonzero, ex_we=1), operand X takes alu_res instead of the register-file value. This applies independently to rs1 and rs2.
- Stall:
  - instr_ready=0, so no accept occurs.
  - The register file is not written; the pending result is retired at the first edge with stall=0.
- Opcodes are not checked. Unsupported encodings pass through and the resulting ALU value (0) is written if we=1.
- Instructions with we=0 occupy the execute stage for one cycle and produce no write and no wb_valid.
- dbg_data reflects the register-file contents before the current edge. A same-cycle write is visible on dbg_data only after the edge.

Test Plan:
- Reset then dbg sweep over 0..7 -> all dbg_data=0; alu_opsel=4'b1111; wb_valid=0; instr_ready=1.
- Seed registers, then issue r3=r1+r2 (op 0000), with r1=5 and r2=7 seeded via pass-through op 0100 -> reg_1=5, reg_2=7 one cycle after accept; then wb_valid=1, wb_rd=3, wb_data=12; dbg r3=12.
- Back-to-back dependency: r4=r3-r1 (0011) issued on the cycle right after r3=r1+r2 -> reg_1 forwarded = 12; r4=7; no bubble.
- Stall: hold stall=1 for 3 cycles with an instruction in execute -> instr_ready=0; ALU inputs stable; no wb_valid during the stall; single write on release.
- Write to r0 with op 1011 (~r1) and we=1 -> no wb_valid; dbg r0=0. Then instruction with we=0 -> no write.
- Assert rst mid-stream, with an instruction in execute (r5=r1^r2, op 1010) -> r5 stays 0; all outputs at reset values immediately (asynchronous).
